// File: rtl/jk_bank_counter.sv
// WIDTH-bit bank of JK flops that doubles as a modulo-MODULUS up/down counter
// with clamped parallel load; q1 is always the complement of the same register.
module jk_bank_counter #(
    parameter int              WIDTH   = 4,
    parameter longint unsigned MODULUS = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q1,
    output logic             tc,
    output logic             wrap
);

    localparam logic [1:0] MODE_JK   = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // Top count value; kept in WIDTH bits so MODULUS = 2^WIDTH never overflows.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;

    assign q  = q_reg;
    assign q1 = ~q_reg;

    assign tc = en & (((mode == MODE_UP)   & (q_reg >= MAX_VAL)) |
                      ((mode == MODE_DOWN) & (q_reg == '0)));

    always_comb begin
        q_next = q_reg;
        if (en) begin
            case (mode)
                MODE_JK:   q_next = (j & ~q_reg) | (~k & q_reg);
                MODE_UP:   q_next = (q_reg >= MAX_VAL) ? '0 : q_reg + ONE;
                MODE_DOWN: begin
                    if (q_reg == '0 || q_reg > MAX_VAL)
                        q_next = MAX_VAL;
                    else
                        q_next = q_reg - ONE;
                end
                MODE_LOAD: q_next = (load_val > MAX_VAL) ? MAX_VAL : load_val;
                default:   q_next = q_reg;
            endcase
        end
    end

    // A wrap happens exactly when tc is high at the edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q_reg <= '0;
            wrap  <= 1'b0;
        end else begin
            q_reg <= q_next;
            wrap  <= tc;
        end
    end

endmodule

// File: tb/tb_jk_bank_counter.sv
// Bench for jk_bank_counter: MODULUS=10 and MODULUS=16 instances on shared
// stimulus, compared against an integer reference model of the counting rules.
module tb_jk_bank_counter;

    logic       clock;
    logic       reset_n;
    logic       en;
    logic [1:0] mode;
    logic [3:0] j, k, load_val;
    logic [3:0] q10, q1_10, q16, q1_16;
    logic       tc10, wrap10, tc16, wrap16;

    int total  = 0;
    int passed = 0;

    int mq10, mq16;
    bit mw10, mw16;

    jk_bank_counter #(.WIDTH(4), .MODULUS(10)) dut10 (
        .clock(clock), .reset_n(reset_n), .en(en), .mode(mode), .j(j), .k(k),
        .load_val(load_val), .q(q10), .q1(q1_10), .tc(tc10), .wrap(wrap10)
    );

    jk_bank_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
        .clock(clock), .reset_n(reset_n), .en(en), .mode(mode), .j(j), .k(k),
        .load_val(load_val), .q(q16), .q1(q1_16), .tc(tc16), .wrap(wrap16)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference model: next value as plain integer arithmetic on 0..15.
    function automatic int model_next(input int m, input int qv, input logic e,
                                      input logic [1:0] md, input logic [3:0] jj,
                                      input logic [3:0] kk, input logic [3:0] lv,
                                      output bit w);
        int r;
        int b;
        w = 0;
        if (!e) return qv;
        case (md)
            2'd0: begin
                r = 0;
                for (int i = 0; i < 4; i++) begin
                    b = (qv >> i) & 1;
                    if (jj[i] && kk[i]) b = 1 - b;
                    else if (jj[i])     b = 1;
                    else if (kk[i])     b = 0;
                    r = r + (b << i);
                end
                return r;
            end
            2'd1: begin
                if (qv >= m - 1) begin w = 1; return 0; end
                return qv + 1;
            end
            2'd2: begin
                if (qv == 0) begin w = 1; return m - 1; end
                if (qv > m - 1) return m - 1;
                return qv - 1;
            end
            default: return (int'(lv) < m) ? int'(lv) : m - 1;
        endcase
    endfunction

    function automatic bit model_tc(input int m, input int qv, input logic e, input logic [1:0] md);
        return e && ((md == 2'd1 && qv >= m - 1) || (md == 2'd2 && qv == 0));
    endfunction

    task automatic check_state();
        chk("q10", 32'(q10), 32'(mq10));
        chk("q1_10", 32'(q1_10), 32'(~mq10 & 15));
        chk("wrap10", 32'(wrap10), 32'(mw10));
        chk("q16", 32'(q16), 32'(mq16));
        chk("q1_16", 32'(q1_16), 32'(~mq16 & 15));
        chk("wrap16", 32'(wrap16), 32'(mw16));
    endtask

    // Called shortly after a rising edge; drives inputs, checks tc, advances one edge.
    task automatic tick(input logic e, input logic [1:0] md, input logic [3:0] jj,
                        input logic [3:0] kk, input logic [3:0] lv);
        en = e; mode = md; j = jj; k = kk; load_val = lv;
        #1;
        chk("tc10", 32'(tc10), 32'(model_tc(10, mq10, e, md)));
        chk("tc16", 32'(tc16), 32'(model_tc(16, mq16, e, md)));
        mq10 = model_next(10, mq10, e, md, jj, kk, lv, mw10);
        mq16 = model_next(16, mq16, e, md, jj, kk, lv, mw16);
        @(posedge clock);
        #1;
        check_state();
    endtask

    task automatic reset_pulse();
        #2 reset_n = 1'b0;
        #1;
        mq10 = 0; mw10 = 0; mq16 = 0; mw16 = 0;
        check_state();
        #1 reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        en = 1'b0; mode = 2'd0; j = '0; k = '0; load_val = '0;
        mq10 = 0; mw10 = 0; mq16 = 0; mw16 = 0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_q", 32'(q10), 32'h0);
        chk("rst_q1", 32'(q1_10), 32'hF);
        chk("rst_wrap", 32'(wrap10), 32'h0);
        reset_n = 1'b1;

        // Reset mid-count, then count up from zero
        tick(1, 2'd3, 4'h0, 4'h0, 4'd7);
        chk("load7", 32'(q10), 32'd7);
        reset_pulse();
        chk("midrst_q", 32'(q10), 32'd0);
        chk("midrst_q1", 32'(q1_10), 32'hF);
        repeat (3) tick(1, 2'd1, 4'h0, 4'h0, 4'h0);
        chk("up3", 32'(q10), 32'd3);

        // Up wrap
        tick(1, 2'd3, 4'h0, 4'h0, 4'd8);
        tick(1, 2'd1, 4'h0, 4'h0, 4'h0);
        chk("up9", 32'(q10), 32'd9);
        chk("up9_tc", 32'(tc10), 32'd1);
        tick(1, 2'd1, 4'h0, 4'h0, 4'h0);
        chk("upwrap_q", 32'(q10), 32'd0);
        chk("upwrap_w", 32'(wrap10), 32'd1);
        tick(1, 2'd1, 4'h0, 4'h0, 4'h0);
        chk("after_wrap_q", 32'(q10), 32'd1);
        chk("after_wrap_w", 32'(wrap10), 32'd0);

        // Down wrap and out-of-range recovery
        tick(1, 2'd3, 4'h0, 4'h0, 4'd0);
        tick(1, 2'd2, 4'h0, 4'h0, 4'h0);
        chk("dnwrap_q", 32'(q10), 32'd9);
        chk("dnwrap_w", 32'(wrap10), 32'd1);
        tick(1, 2'd0, 4'hF, 4'h0, 4'h0);
        chk("jk_set", 32'(q10), 32'd15);
        tick(1, 2'd2, 4'h0, 4'h0, 4'h0);
        chk("oor_q", 32'(q10), 32'd9);
        chk("oor_w", 32'(wrap10), 32'd0);

        // JK truth table: bit0 set, bit1 toggle, bit2 reset, bit3 hold
        tick(1, 2'd3, 4'h0, 4'h0, 4'b0101);
        tick(1, 2'd0, 4'b0011, 4'b0110, 4'h0);
        chk("jk_mix", 32'(q10), 32'b0011);
        tick(1, 2'd0, 4'hF, 4'hF, 4'h0);
        chk("jk_tog_q", 32'(q10), 32'b1100);
        chk("jk_tog_q1", 32'(q1_10), 32'b0011);

        // Load clamp and enable hold
        tick(1, 2'd3, 4'h0, 4'h0, 4'd12);
        chk("clamp", 32'(q10), 32'd9);
        repeat (5) tick(0, 2'd1, 4'h0, 4'h0, 4'h0);
        chk("hold_q", 32'(q10), 32'd9);
        chk("hold_tc", 32'(tc10), 32'd0);
        chk("hold_w", 32'(wrap10), 32'd0);

        // Full-range modulus: wrap both directions
        tick(1, 2'd3, 4'h0, 4'h0, 4'd15);
        tick(1, 2'd1, 4'h0, 4'h0, 4'h0);
        chk("m16_up_q", 32'(q16), 32'd0);
        chk("m16_up_w", 32'(wrap16), 32'd1);
        tick(1, 2'd2, 4'h0, 4'h0, 4'h0);
        chk("m16_dn_q", 32'(q16), 32'd15);
        chk("m16_dn_w", 32'(wrap16), 32'd1);

        // Randomised traffic with occasional async resets
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 49) == 0)
                reset_pulse();
            tick(($urandom_range(0, 4) != 0), 2'($urandom_range(0, 3)),
                 4'($urandom), 4'($urandom), 4'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
